// File: rtl/rgb_hue_pwm_pkg.sv
// rgb_pkg: types and constants shared by the hue-wheel PWM design.
//   sector_t    : hue sector encoding, 0..5 (red->yellow ... magenta->red)
//   NUM_SECTORS : number of sectors on the hue wheel
package rgb_pkg;

  typedef enum logic [2:0] {
    SEC_RY = 3'd0,
    SEC_YG = 3'd1,
    SEC_GC = 3'd2,
    SEC_CB = 3'd3,
    SEC_BM = 3'd4,
    SEC_MR = 3'd5
  } sector_t;

  localparam int NUM_SECTORS = 6;

endpackage

// File: rtl/rgb_hue_pwm_if.sv
// rgb_hue_pwm_if: control and LED-pin bundle of the hue-wheel generator.
//   master : drives en/hold/dir/restart/bright, observes the pins and status
//   slave  : the generator side
//   en, hold, dir, restart : run, freeze, direction and restart controls
//   bright                 : global brightness, all-ones = full
//   RGB_R/G/B              : registered PWM pin levels
//   hue_sector             : registered current sector 0..5
//   wrap                   : one-cycle pulse when the hue wraps past red
interface rgb_hue_pwm_if #(
  parameter int PWM_BITS = 8
);
  logic                en;
  logic                hold;
  logic                dir;
  logic                restart;
  logic [PWM_BITS-1:0] bright;
  logic                RGB_R;
  logic                RGB_G;
  logic                RGB_B;
  logic [2:0]          hue_sector;
  logic                wrap;

  modport master (
    output en, hold, dir, restart, bright,
    input  RGB_R, RGB_G, RGB_B, hue_sector, wrap
  );

  modport slave (
    input  en, hold, dir, restart, bright,
    output RGB_R, RGB_G, RGB_B, hue_sector, wrap
  );
endinterface

// File: rtl/rgb_hue_pwm_hue_to_level.sv
// hue_to_level: combinational mapping of a hue position to R/G/B levels.
//   sector_i  : current sector 0..5
//   frac_i    : fine position inside the sector
//   level_*_o : unscaled channel levels, MX = all-ones
// Each channel is a trapezoid: rise over one sector, full for two, fall over
// one, dark for two. Sector codes 6/7 cannot occur; they map to dark.
module hue_to_level
  import rgb_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  sector_t             sector_i,
  input  logic [PWM_BITS-1:0] frac_i,
  output logic [PWM_BITS-1:0] level_r_o,
  output logic [PWM_BITS-1:0] level_g_o,
  output logic [PWM_BITS-1:0] level_b_o
);

  logic [PWM_BITS-1:0] up;
  logic [PWM_BITS-1:0] dn;
  logic [PWM_BITS-1:0] mx;

  assign mx = '1;
  assign up = frac_i;
  assign dn = ~frac_i;  // MX - frac

  always_comb begin
    level_r_o = '0;
    level_g_o = '0;
    level_b_o = '0;
    case (sector_i)
      SEC_RY: begin level_r_o = mx; level_g_o = up; end
      SEC_YG: begin level_r_o = dn; level_g_o = mx; end
      SEC_GC: begin level_g_o = mx; level_b_o = up; end
      SEC_CB: begin level_g_o = dn; level_b_o = mx; end
      SEC_BM: begin level_r_o = up; level_b_o = mx; end
      SEC_MR: begin level_r_o = mx; level_b_o = dn; end
      default: ;
    endcase
  end

endmodule

// File: rtl/rgb_hue_pwm.sv
// rgb_hue_pwm: HSV hue-wheel sweep driving three glitch-free PWM LED pins.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : rgb_hue_pwm_if.slave (controls in, pins/status out)
// The hue register is {sector, frac}; it steps once every STEP_INTERVAL
// running cycles. Channel duties are latched only at the PWM period
// boundary so a pin never changes its duty mid-period.
module rgb_hue_pwm
  import rgb_pkg::*;
#(
  parameter int PWM_BITS      = 8,
  parameter int STEP_INTERVAL = 7812
) (
  input logic          clk,
  input logic          rst_n,
  rgb_hue_pwm_if.slave bus
);

  localparam int HUE_W   = 3 + PWM_BITS;
  localparam int SCALE_W = 2 * PWM_BITS + 1;
  localparam int STEP_W  = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;

  localparam logic [HUE_W-1:0]    HUE_MAX   = HUE_W'(NUM_SECTORS * (1 << PWM_BITS) - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_INTERVAL - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;

  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [HUE_W-1:0]    hue_q, hue_d;
  logic                wrap_q, wrap_d;
  logic [2:0]          sector_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] level [3];
  logic [SCALE_W-1:0]  bright_p1;
  logic [2:0]          pin;
  sector_t             hue_sec;

  // Hue / step-counter next state; restart beats ~en beats hold beats tick.
  always_comb begin
    step_cnt_d = step_cnt_q;
    hue_d      = hue_q;
    wrap_d     = 1'b0;
    if (bus.restart) begin
      step_cnt_d = '0;
      hue_d      = '0;
    end else if (bus.en && !bus.hold) begin
      if (step_cnt_q == STEP_LAST) begin
        step_cnt_d = '0;
        if (bus.dir) begin
          if (hue_q == '0) begin
            hue_d  = HUE_MAX;
            wrap_d = 1'b1;
          end else begin
            hue_d = hue_q - HUE_W'(1);
          end
        end else begin
          if (hue_q == HUE_MAX) begin
            hue_d  = '0;
            wrap_d = 1'b1;
          end else begin
            hue_d = hue_q + HUE_W'(1);
          end
        end
      end else begin
        step_cnt_d = step_cnt_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
      hue_q      <= '0;
      wrap_q     <= 1'b0;
      sector_q   <= 3'd0;
      pwm_cnt_q  <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
      hue_q      <= hue_d;
      wrap_q     <= wrap_d;
      sector_q   <= hue_q[HUE_W-1 -: 3];
      pwm_cnt_q  <= pwm_cnt_q + PWM_BITS'(1);  // free-running
    end
  end

  assign hue_sec = sector_t'(hue_q[HUE_W-1 -: 3]);

  hue_to_level #(
    .PWM_BITS (PWM_BITS)
  ) u_hue_to_level (
    .sector_i  (hue_sec),
    .frac_i    (hue_q[PWM_BITS-1:0]),
    .level_r_o (level[0]),
    .level_g_o (level[1]),
    .level_b_o (level[2])
  );

  assign bright_p1 = SCALE_W'(bus.bright) + SCALE_W'(1);

  // Per-channel brightness scaling, period-boundary duty latch and pin.
  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pin_q;

    // level*(bright+1) < 2^(2*PWM_BITS), so the shifted product fits.
    assign duty_d = PWM_BITS'((SCALE_W'(level[gi]) * bright_p1) >> PWM_BITS);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_q <= '0;
        pin_q  <= 1'b0;
      end else begin
        if (pwm_cnt_q == PWM_MAX) duty_q <= duty_d;
        pin_q <= bus.en & (pwm_cnt_q < duty_q);
      end
    end

    assign pin[gi] = pin_q;
  end

  assign bus.RGB_R      = pin[0];
  assign bus.RGB_G      = pin[1];
  assign bus.RGB_B      = pin[2];
  assign bus.hue_sector = sector_q;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_rgb_hue_pwm.sv
module tb_rgb_hue_pwm;

  localparam int PB    = 4;
  localparam int SI    = 2;
  localparam int FINE  = 1 << PB;
  localparam int MX    = FINE - 1;
  localparam int HUE_N = 6 * FINE;

  logic clk = 1'b0;
  logic rst_n;

  rgb_hue_pwm_if #(.PWM_BITS(PB)) bus ();

  rgb_hue_pwm #(
    .PWM_BITS      (PB),
    .STEP_INTERVAL (SI)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- behavioural model ----------------
  int       m_hue, m_step, m_pwm, m_sector;
  int       m_duty [3];
  bit [2:0] m_rgb;
  bit       m_wrap;

  // Trapezoid: rise one sector, full two, fall one, dark two.
  function automatic int ramp(int x);
    if (x < FINE)          return x;
    else if (x < 3 * FINE) return MX;
    else if (x < 4 * FINE) return 4 * FINE - 1 - x;
    else                   return 0;
  endfunction

  // Channel 0=R, 1=G, 2=B; each channel's ramp starts two sectors apart.
  function automatic int level_of(int ch, int h);
    int off;
    off = (ch == 0) ? 2 * FINE : (ch == 1) ? 0 : 4 * FINE;
    return ramp((h + off) % HUE_N);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hue = 0; m_step = 0; m_pwm = 0; m_sector = 0;
      m_rgb = '0; m_wrap = 1'b0;
      for (int c = 0; c < 3; c++) m_duty[c] = 0;
    end else begin
      for (int c = 0; c < 3; c++) m_rgb[c] = bus.en && (m_pwm < m_duty[c]);
      m_sector = m_hue / FINE;
      if (m_pwm == MX)
        for (int c = 0; c < 3; c++)
          m_duty[c] = level_of(c, m_hue) * (int'(bus.bright) + 1) / FINE;
      m_pwm  = (m_pwm + 1) % FINE;
      m_wrap = 1'b0;
      if (bus.restart) begin
        m_hue = 0; m_step = 0;
      end else if (bus.en && !bus.hold) begin
        if (m_step == SI - 1) begin
          m_step = 0;
          if (!bus.dir) begin
            m_wrap = (m_hue == HUE_N - 1);
            m_hue  = (m_hue + 1) % HUE_N;
          end else begin
            m_wrap = (m_hue == 0);
            m_hue  = (m_hue + HUE_N - 1) % HUE_N;
          end
        end else begin
          m_step++;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [6:0] exp_v, act_v;
    if (rst_n === 1'b1) begin
      exp_v = {m_rgb[0], m_rgb[1], m_rgb[2], 3'(m_sector), m_wrap};
      act_v = {bus.RGB_R, bus.RGB_G, bus.RGB_B, bus.hue_sector, bus.wrap};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_compare @%0t: got rgb/sector/wrap=%b required %b", $time, act_v, exp_v);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d required %0d", name, $time, act, exp);
    end else begin
      $display("check %s: %0d", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_high(output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    repeat (FINE) begin
      @(negedge clk);
      r += int'(bus.RGB_R); g += int'(bus.RGB_G); b += int'(bus.RGB_B);
    end
  endtask

  task automatic pulse_restart();
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    lit({tag, "_rgb"}, int'({bus.RGB_R, bus.RGB_G, bus.RGB_B}), 0);
    lit({tag, "_sector"}, int'(bus.hue_sector), 0);
    lit({tag, "_wrap"}, int'(bus.wrap), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r, g, b, n, at, tog, found;
    logic prev;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.hold = 1'b0; bus.dir = 1'b0; bus.restart = 1'b0;
    bus.bright = '1;
    cyc(3);
    rst_n = 1'b1;

    // 1: reset mid-run, then first tick after two edges
    bus.en = 1'b1;
    cyc(50);
    async_reset("reset");
    cyc(1);
    lit("hue_after_1_edge", int'(dut.hue_q), 0);
    cyc(1);
    lit("hue_after_2_edges", int'(dut.hue_q), 1);

    // 2: one full revolution, ascending
    pulse_restart();
    n = 0; at = 0;
    for (int k = 1; k <= 2 * HUE_N; k++) begin
      @(negedge clk);
      if (bus.wrap) begin n++; at = k; end
      if (k == 100) lit("rev_sector_at_100", int'(bus.hue_sector), 3);
    end
    lit("rev_wrap_count", n, 1);
    lit("rev_wrap_cycle", at, 2 * HUE_N);

    // 3: duty at hue {0,8}, full brightness
    pulse_restart();
    cyc(16);
    bus.hold = 1'b1;
    lit("held_hue", int'(dut.hue_q), 8);
    cyc(40);
    count_high(r, g, b);
    lit("duty_r_full", r, 15);
    lit("duty_g_full", g, 8);
    lit("duty_b_full", b, 0);

    // 4: brightness 7, changed mid-period (model checks the boundary)
    cyc(5);
    bus.bright = 4'd7;
    cyc(40);
    count_high(r, g, b);
    lit("duty_r_dim", r, 7);
    lit("duty_g_dim", g, 4);
    lit("duty_b_dim", b, 0);

    // 5: descending wrap from red
    pulse_restart();
    bus.dir = 1'b1; bus.hold = 1'b0; bus.bright = '1;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (bus.wrap) found = 1;
    end
    bus.hold = 1'b1;
    lit("desc_wrap_seen", found, 1);
    if (found != 0) begin
      lit("desc_hue", int'(dut.hue_q), HUE_N - 1);
      @(negedge clk);
      lit("desc_sector", int'(bus.hue_sector), 5);
      lit("desc_wrap_one_cycle", int'(bus.wrap), 0);
    end

    // 6: restart in a tick cycle, long hold, en=0
    bus.dir = 1'b0; bus.hold = 1'b0;
    cyc(10);
    found = 0;
    for (int i = 0; i < 4 && found == 0; i++) begin
      if (m_step == SI - 1) found = 1;
      else @(negedge clk);
    end
    lit("tick_cycle_found", found, 1);
    pulse_restart();
    lit("restart_tick_hue", int'(dut.hue_q), 0);
    lit("restart_tick_wrap", int'(bus.wrap), 0);
    bus.hold = 1'b1;
    tog = 0;
    prev = bus.RGB_R;
    repeat (100) begin
      @(negedge clk);
      if (bus.RGB_R != prev) tog++;
      prev = bus.RGB_R;
    end
    lit("hold_hue_unchanged", int'(dut.hue_q), 0);
    lit("hold_pwm_toggles", int'(tog > 0), 1);
    bus.en = 1'b0;
    @(negedge clk);
    lit("en_off_rgb", int'({bus.RGB_R, bus.RGB_G, bus.RGB_B}), 0);

    // Randomised phase, model checked every cycle
    bus.en = 1'b1; bus.hold = 1'b0;
    for (int it = 0; it < 2500; it++) begin
      @(negedge clk);
      bus.restart = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 49) == 0) bus.en = ~bus.en | ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 39) == 0) bus.hold = ~bus.hold;
      if ($urandom_range(0, 79) == 0) bus.dir = ~bus.dir;
      if ($urandom_range(0, 29) == 0) bus.bright = 4'($urandom_range(0, 15));
      if (it == 1200) begin
        bus.restart = 1'b0;
        async_reset("midrun_reset");
      end
    end
    bus.restart = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
